hazard_ctrl_pipe: RTL and testbench

- Parametrised control-path pipeline for the 5-stage RV32I core.
- Carries decode-stage control bundles through the D/E, E/M and M/W registers, and resolves all six branch conditions in E.
- Contains the hazard logic: forwarding selects, load-use interlock, and branch/jump flush.
- Supports two hazard modes (forwarding or interlock-only) and has saturating stall/flush performance counters. It sits between control_unit and the datapath.

---
 rtl/pipe_ctrl_pkg.sv | 54 +++++
 rtl/hazard_ctrl_pipe_hazard_unit.sv | 75 +++++++
 rtl/hazard_ctrl_pipe.sv | 181 ++++++++++++++++++
 tb/tb_hazard_ctrl_pipe.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the control-path pipeline and its hazard unit.
// Enums, branch funct3 codes and the per-stage control bundles.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JAL    = 2'b10,
        PC_JALR   = 2'b11
    } pcsrc_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic [3:0] alu_control;
        logic       alu_src;
        logic [2:0] funct3;
    } ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } wb_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_pipe_hazard_unit.sv
// Combinational hazard detection: forwarding selects, data-hazard
// stalls and control-hazard flushes for the E stage.
module hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter bit FWD_EN         = 1'b1,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_e_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_e_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_e_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
    input  logic                      reg_write_e_i,
    input  logic [1:0]                result_src_e_i,
    input  logic                      reg_write_m_i,
    input  logic                      reg_write_w_i,
    input  logic [1:0]                pcsrc_e_i,
    output logic                      stall_f_o,
    output logic                      stall_d_o,
    output logic                      flush_d_o,
    output logic                      flush_e_o,
    output logic [1:0]                fwd_a_o,
    output logic [1:0]                fwd_b_o
);

    fwd_sel_t fwd_a, fwd_b;
    logic     load_use, interlock, data_haz, ctrl_haz;

    function automatic logic hit(
        input logic                      we,
        input logic [REG_ADDR_WIDTH-1:0] rd,
        input logic [REG_ADDR_WIDTH-1:0] rs
    );
        return we && (rd != '0) && (rd == rs);
    endfunction

    always_comb begin
        fwd_a = FWD_RF;
        if (hit(reg_write_m_i, rd_m_i, rs1_e_i))
            fwd_a = FWD_M;
        else if (hit(reg_write_w_i, rd_w_i, rs1_e_i))
            fwd_a = FWD_W;

        fwd_b = FWD_RF;
        if (hit(reg_write_m_i, rd_m_i, rs2_e_i))
            fwd_b = FWD_M;
        else if (hit(reg_write_w_i, rd_w_i, rs2_e_i))
            fwd_b = FWD_W;

        load_use = (result_src_e_i == RES_LOAD)
                && (hit(1'b1, rd_e_i, rs1_d_i)
                 || hit(1'b1, rd_e_i, rs2_d_i));

        // W is never checked: the register file writes before it reads
        interlock = hit(reg_write_e_i, rd_e_i, rs1_d_i)
                 || hit(reg_write_e_i, rd_e_i, rs2_d_i)
                 || hit(reg_write_m_i, rd_m_i, rs1_d_i)
                 || hit(reg_write_m_i, rd_m_i, rs2_d_i);

        data_haz = FWD_EN ? load_use : interlock;
        ctrl_haz = (pcsrc_e_i != PC_PLUS4);
    end

    // a wrong-path instruction in D must be squashed, not held
    assign stall_f_o = data_haz && !ctrl_haz;
    assign stall_d_o = data_haz && !ctrl_haz;
    assign flush_d_o = ctrl_haz;
    assign flush_e_o = data_haz || ctrl_haz;
    assign fwd_a_o   = FWD_EN ? fwd_a : FWD_RF;
    assign fwd_b_o   = FWD_EN ? fwd_b : FWD_RF;

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Control-path D/E, E/M, M/W registers with branch resolution in E,
// hazard unit and saturating stall/flush performance counters.
module hazard_ctrl_pipe
    import pipe_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter bit FWD_EN         = 1'b1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RegWriteD_i,
    input  logic [1:0]                ResultSrcD_i,
    input  logic                      MemWriteD_i,
    input  logic                      JumpD_i,
    input  logic                      JalrD_i,
    input  logic                      BranchD_i,
    input  logic [3:0]                ALUControlD_i,
    input  logic                      ALUSrcD_i,
    input  logic [2:0]                funct3D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdD_i,
    input  logic                      ZeroE_i,
    input  logic                      LtE_i,
    input  logic                      LtuE_i,
    output logic [3:0]                ALUControlE_o,
    output logic                      ALUSrcE_o,
    output logic                      MemWriteM_o,
    output logic                      RegWriteW_o,
    output logic [1:0]                ResultSrcW_o,
    output logic [REG_ADDR_WIDTH-1:0] RdW_o,
    output logic [1:0]                PCSrcE_o,
    output logic                      StallF_o,
    output logic                      StallD_o,
    output logic                      FlushD_o,
    output logic                      FlushE_o,
    output logic [1:0]                ForwardAE_o,
    output logic [1:0]                ForwardBE_o,
    output logic [CNT_WIDTH-1:0]      StallCnt_o,
    output logic [CNT_WIDTH-1:0]      FlushCnt_o
);

    // counters never exceed the datapath width they are read through
    localparam int CW = (CNT_WIDTH < DATA_WIDTH) ? CNT_WIDTH : DATA_WIDTH;

    ctrl_t     e_d, e_q;
    mem_ctrl_t m_q;
    wb_ctrl_t  w_q;

    logic [REG_ADDR_WIDTH-1:0] rs1_e_d, rs2_e_d, rd_e_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_e_q, rs2_e_q, rd_e_q;
    logic [REG_ADDR_WIDTH-1:0] rd_m_q, rd_w_q;
    logic [CW-1:0]             stall_cnt_d, stall_cnt_q;
    logic [CW-1:0]             flush_cnt_d, flush_cnt_q;

    pcsrc_t pcsrc_e;
    logic   br_taken;
    logic   stall_f, stall_d, flush_d, flush_e;
    logic [1:0] fwd_a, fwd_b;

    always_comb begin
        br_taken = 1'b0;
        case (e_q.funct3)
            F3_BEQ:  br_taken = ZeroE_i;
            F3_BNE:  br_taken = !ZeroE_i;
            F3_BLT:  br_taken = LtE_i;
            F3_BGE:  br_taken = !LtE_i;
            F3_BLTU: br_taken = LtuE_i;
            F3_BGEU: br_taken = !LtuE_i;
            default: br_taken = 1'b0;
        endcase

        pcsrc_e = PC_PLUS4;
        if (e_q.jalr)
            pcsrc_e = PC_JALR;
        else if (e_q.jump)
            pcsrc_e = PC_JAL;
        else if (e_q.branch && br_taken)
            pcsrc_e = PC_BRANCH;
    end

    hazard_unit #(
        .FWD_EN         (FWD_EN),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard (
        .rs1_d_i        (Rs1D_i),
        .rs2_d_i        (Rs2D_i),
        .rs1_e_i        (rs1_e_q),
        .rs2_e_i        (rs2_e_q),
        .rd_e_i         (rd_e_q),
        .rd_m_i         (rd_m_q),
        .rd_w_i         (rd_w_q),
        .reg_write_e_i  (e_q.reg_write),
        .result_src_e_i (e_q.result_src),
        .reg_write_m_i  (m_q.reg_write),
        .reg_write_w_i  (w_q.reg_write),
        .pcsrc_e_i      (pcsrc_e),
        .stall_f_o      (stall_f),
        .stall_d_o      (stall_d),
        .flush_d_o      (flush_d),
        .flush_e_o      (flush_e),
        .fwd_a_o        (fwd_a),
        .fwd_b_o        (fwd_b)
    );

    always_comb begin
        e_d     = '0;
        rs1_e_d = '0;
        rs2_e_d = '0;
        rd_e_d  = '0;
        if (!flush_e) begin
            e_d.reg_write   = RegWriteD_i;
            e_d.result_src  = ResultSrcD_i;
            e_d.mem_write   = MemWriteD_i;
            e_d.jump        = JumpD_i;
            e_d.jalr        = JalrD_i;
            e_d.branch      = BranchD_i;
            e_d.alu_control = ALUControlD_i;
            e_d.alu_src     = ALUSrcD_i;
            e_d.funct3      = funct3D_i;
            rs1_e_d         = Rs1D_i;
            rs2_e_d         = Rs2D_i;
            rd_e_d          = RdD_i;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_d && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CW'(1);
        flush_cnt_d = flush_cnt_q;
        if (flush_d && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            rs1_e_q     <= '0;
            rs2_e_q     <= '0;
            rd_e_q      <= '0;
            rd_m_q      <= '0;
            rd_w_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            rs1_e_q     <= rs1_e_d;
            rs2_e_q     <= rs2_e_d;
            rd_e_q      <= rd_e_d;
            m_q         <= '{reg_write:  e_q.reg_write,
                             result_src: e_q.result_src,
                             mem_write:  e_q.mem_write};
            rd_m_q      <= rd_e_q;
            w_q         <= '{reg_write:  m_q.reg_write,
                             result_src: m_q.result_src};
            rd_w_q      <= rd_m_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ALUControlE_o = e_q.alu_control;
    assign ALUSrcE_o     = e_q.alu_src;
    assign MemWriteM_o   = m_q.mem_write;
    assign RegWriteW_o   = w_q.reg_write;
    assign ResultSrcW_o  = w_q.result_src;
    assign RdW_o         = rd_w_q;
    assign PCSrcE_o      = pcsrc_e;
    assign StallF_o      = stall_f;
    assign StallD_o      = stall_d;
    assign FlushD_o      = flush_d;
    assign FlushE_o      = flush_e;
    assign ForwardAE_o   = fwd_a;
    assign ForwardBE_o   = fwd_b;
    assign StallCnt_o    = CNT_WIDTH'(stall_cnt_q);
    assign FlushCnt_o    = CNT_WIDTH'(flush_cnt_q);

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Bench for hazard_ctrl_pipe: directed table, interlock/saturation
// sequence and random stimulus against an instruction-level model.
module tb_hazard_ctrl_pipe;

    typedef struct packed {
        logic       regw;
        logic [1:0] rsrc;
        logic       memw;
        logic       jump;
        logic       jalr;
        logic       branch;
        logic [3:0] aluc;
        logic       alusrc;
        logic [2:0] f3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ins_t;

    typedef struct {
        logic       rst;
        ins_t       d;
        logic       z;
        logic       lt;
        logic       ltu;
        logic [1:0] pc;
        logic       stl;
        logic       fd;
        logic       fe;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       rw;
        int         sc;
        int         fc;
    } row_t;

    logic clk = 1'b0;
    logic rst;
    logic i_rw, i_mw, i_j, i_jr, i_br, i_as;
    logic [1:0] i_rs;
    logic [3:0] i_alu;
    logic [2:0] i_f3;
    logic [4:0] i_r1, i_r2, i_rd;
    logic zf, ltf, ltuf;

    logic [3:0] alu_f, alu_i;
    logic as_f, as_i, mw_f, mw_i, rw_f, rw_i;
    logic [1:0] rs_f, rs_i, pc_f, pc_i;
    logic [4:0] rd_f, rd_i;
    logic sf_f, sf_i, sd_f, sd_i, fd_f, fd_i, fe_f, fe_i;
    logic [1:0] fa_f, fa_i, fb_f, fb_i;
    logic [15:0] sc_f, fc_f;
    logic [1:0] sc_i, fc_i;

    logic [23:0] ov_f, ov_i;

    int n = 0;
    int bad = 0;
    int il_stalls = 0;
    int il_fwd = 0;

    ins_t pe[2], pm[2], pw[2];
    int scnt[2], fcnt[2];
    logic [23:0] ev[2];

    always #5 clk = ~clk;

    hazard_ctrl_pipe u_fwd (
        .clk(clk), .rst(rst),
        .RegWriteD_i(i_rw), .ResultSrcD_i(i_rs),
        .MemWriteD_i(i_mw), .JumpD_i(i_j), .JalrD_i(i_jr),
        .BranchD_i(i_br), .ALUControlD_i(i_alu),
        .ALUSrcD_i(i_as), .funct3D_i(i_f3),
        .Rs1D_i(i_r1), .Rs2D_i(i_r2), .RdD_i(i_rd),
        .ZeroE_i(zf), .LtE_i(ltf), .LtuE_i(ltuf),
        .ALUControlE_o(alu_f), .ALUSrcE_o(as_f),
        .MemWriteM_o(mw_f), .RegWriteW_o(rw_f),
        .ResultSrcW_o(rs_f), .RdW_o(rd_f), .PCSrcE_o(pc_f),
        .StallF_o(sf_f), .StallD_o(sd_f),
        .FlushD_o(fd_f), .FlushE_o(fe_f),
        .ForwardAE_o(fa_f), .ForwardBE_o(fb_f),
        .StallCnt_o(sc_f), .FlushCnt_o(fc_f)
    );

    hazard_ctrl_pipe #(.FWD_EN(1'b0), .CNT_WIDTH(2)) u_il (
        .clk(clk), .rst(rst),
        .RegWriteD_i(i_rw), .ResultSrcD_i(i_rs),
        .MemWriteD_i(i_mw), .JumpD_i(i_j), .JalrD_i(i_jr),
        .BranchD_i(i_br), .ALUControlD_i(i_alu),
        .ALUSrcD_i(i_as), .funct3D_i(i_f3),
        .Rs1D_i(i_r1), .Rs2D_i(i_r2), .RdD_i(i_rd),
        .ZeroE_i(zf), .LtE_i(ltf), .LtuE_i(ltuf),
        .ALUControlE_o(alu_i), .ALUSrcE_o(as_i),
        .MemWriteM_o(mw_i), .RegWriteW_o(rw_i),
        .ResultSrcW_o(rs_i), .RdW_o(rd_i), .PCSrcE_o(pc_i),
        .StallF_o(sf_i), .StallD_o(sd_i),
        .FlushD_o(fd_i), .FlushE_o(fe_i),
        .ForwardAE_o(fa_i), .ForwardBE_o(fb_i),
        .StallCnt_o(sc_i), .FlushCnt_o(fc_i)
    );

    assign ov_f = {alu_f, as_f, mw_f, rw_f, rs_f, rd_f, pc_f,
                   sf_f, sd_f, fd_f, fe_f, fa_f, fb_f};
    assign ov_i = {alu_i, as_i, mw_i, rw_i, rs_i, rd_i, pc_i,
                   sf_i, sd_i, fd_i, fe_i, fa_i, fb_i};

    function automatic ins_t mk(logic rw, logic [1:0] rs, logic br,
                                logic j, logic jr, logic [2:0] f3,
                                logic [4:0] rd, logic [4:0] r1,
                                logic [4:0] r2);
        ins_t x;
        x = '0;
        x.regw = rw; x.rsrc = rs; x.branch = br;
        x.jump = j; x.jalr = jr; x.f3 = f3;
        x.rd = rd; x.rs1 = r1; x.rs2 = r2;
        return x;
    endfunction

    function automatic ins_t d_ins();
        ins_t x;
        x.regw = i_rw; x.rsrc = i_rs; x.memw = i_mw;
        x.jump = i_j; x.jalr = i_jr; x.branch = i_br;
        x.aluc = i_alu; x.alusrc = i_as; x.f3 = i_f3;
        x.rd = i_rd; x.rs1 = i_r1; x.rs2 = i_r2;
        return x;
    endfunction

    // RV32I semantics: odd funct3 inverts the even condition
    function automatic bit br_taken(logic [2:0] f3);
        bit base;
        if (f3 == 3'b010 || f3 == 3'b011) return 1'b0;
        base = f3[2] ? (f3[1] ? ltuf : ltf) : zf;
        return base ^ f3[0];
    endfunction

    function automatic bit reads(ins_t d, logic [4:0] r);
        return (r != 0) && (r == d.rs1 || r == d.rs2);
    endfunction

    function automatic logic [1:0] src(int m, ins_t mm, ins_t w,
                                       logic [4:0] rs);
        if (m == 0) return 2'd0;
        if (mm.regw && mm.rd != 0 && mm.rd == rs) return 2'd2;
        if (w.regw && w.rd != 0 && w.rd == rs) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [23:0] model_vec(int m);
        ins_t e, mm, w, d;
        logic [1:0] pc;
        bit ld, ctl, stl;
        e = pe[m]; mm = pm[m]; w = pw[m]; d = d_ins();
        if (e.jalr) pc = 2'd3;
        else if (e.jump) pc = 2'd2;
        else if (e.branch && br_taken(e.f3)) pc = 2'd1;
        else pc = 2'd0;
        if (m == 1)
            ld = (e.rsrc == 2'b01) && reads(d, e.rd);
        else
            ld = (e.regw && reads(d, e.rd))
              || (mm.regw && reads(d, mm.rd));
        ctl = (pc != 0);
        stl = ld && !ctl;
        return {e.aluc, e.alusrc, mm.memw, w.regw, w.rsrc, w.rd, pc,
                stl, stl, ctl, ld || ctl,
                src(m, mm, w, e.rs1), src(m, mm, w, e.rs2)};
    endfunction

    task automatic set_in(logic r, ins_t x, logic z, logic l, logic lu);
        rst = r;
        i_rw = x.regw; i_rs = x.rsrc; i_mw = x.memw;
        i_j = x.jump; i_jr = x.jalr; i_br = x.branch;
        i_alu = x.aluc; i_as = x.alusrc; i_f3 = x.f3;
        i_rd = x.rd; i_r1 = x.rs1; i_r2 = x.rs2;
        zf = z; ltf = l; ltuf = lu;
    endtask

    task automatic sample();
        logic [31:0] oc, ec;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            ev[m] = model_vec(m);
            n++;
            if ((m == 1 ? ov_f : ov_i) !== ev[m]) begin
                bad++;
                $display("FAIL model_sig m=%0d t=%0t got=%h want=%h",
                         m, $time, (m == 1 ? ov_f : ov_i), ev[m]);
            end
            oc = (m == 1) ? {sc_f, fc_f} : {14'd0, sc_i, 14'd0, fc_i};
            ec = {scnt[m][15:0], fcnt[m][15:0]};
            n++;
            if (oc !== ec) begin
                bad++;
                $display("FAIL model_cnt m=%0d t=%0t got=%h want=%h",
                         m, $time, oc, ec);
            end
        end
        il_stalls += int'(sd_i);
        if (fa_i != 0 || fb_i != 0) il_fwd++;
    endtask

    task automatic advance();
        int mx;
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            mx = (m == 1) ? 65535 : 3;
            if (rst) begin
                pe[m] = '0; pm[m] = '0; pw[m] = '0;
                scnt[m] = 0; fcnt[m] = 0;
            end else begin
                pw[m] = pm[m];
                pm[m] = pe[m];
                pe[m] = ev[m][4] ? '0 : d_ins();
                if (ev[m][6] && scnt[m] < mx) scnt[m]++;
                if (ev[m][5] && fcnt[m] < mx) fcnt[m]++;
            end
        end
        #1;
    endtask

    function automatic row_t row(logic r, ins_t d, logic z, logic l,
                                 logic lu, logic [1:0] pc, logic stl,
                                 logic fd, logic fe, logic [1:0] fa,
                                 logic [1:0] fb, logic rw, int sc,
                                 int fc);
        row_t x;
        x.rst = r; x.d = d; x.z = z; x.lt = l; x.ltu = lu;
        x.pc = pc; x.stl = stl; x.fd = fd; x.fe = fe;
        x.fa = fa; x.fb = fb; x.rw = rw; x.sc = sc; x.fc = fc;
        return x;
    endfunction

    row_t tbl[26];
    ins_t NOP, ADD5, SUB6, UNR, AND9, ADD0, USE0, LW7, ADD8;
    ins_t BNE, BGEU, JALR, BEQX, USE5, rnd;

    initial begin
        NOP  = '0;
        ADD5 = mk(1, 0, 0, 0, 0, 0, 5, 1, 2);
        SUB6 = mk(1, 0, 0, 0, 0, 0, 6, 5, 5);
        UNR  = mk(1, 0, 0, 0, 0, 0, 10, 3, 4);
        AND9 = mk(1, 0, 0, 0, 0, 0, 9, 5, 5);
        ADD0 = mk(1, 0, 0, 0, 0, 0, 0, 1, 2);
        USE0 = mk(1, 0, 0, 0, 0, 0, 11, 0, 0);
        LW7  = mk(1, 1, 0, 0, 0, 0, 7, 1, 0);
        ADD8 = mk(1, 0, 0, 0, 0, 0, 8, 7, 1);
        BNE  = mk(0, 0, 1, 0, 0, 3'b001, 0, 1, 2);
        BGEU = mk(0, 0, 1, 0, 0, 3'b111, 0, 1, 2);
        JALR = mk(1, 2, 0, 1, 1, 0, 1, 2, 0);
        BEQX = mk(0, 1, 1, 0, 0, 3'b000, 7, 1, 2);
        USE5 = mk(1, 0, 0, 0, 0, 0, 12, 5, 0);

        tbl[0]  = row(0, ADD5, 0,0,0, 0,0,0,0, 0,0, 0, 0,0);
        tbl[1]  = row(0, SUB6, 0,0,0, 0,0,0,0, 0,0, 0, 0,0);
        tbl[2]  = row(0, ADD5, 0,0,0, 0,0,0,0, 2,2, 0, 0,0);
        tbl[3]  = row(0, UNR,  0,0,0, 0,0,0,0, 0,0, 1, 0,0);
        tbl[4]  = row(0, AND9, 0,0,0, 0,0,0,0, 0,0, 1, 0,0);
        tbl[5]  = row(0, ADD0, 0,0,0, 0,0,0,0, 1,1, 1, 0,0);
        tbl[6]  = row(0, USE0, 0,0,0, 0,0,0,0, 0,0, 1, 0,0);
        tbl[7]  = row(0, NOP,  0,0,0, 0,0,0,0, 0,0, 1, 0,0);
        tbl[8]  = row(0, LW7,  0,0,0, 0,0,0,0, 0,0, 1, 0,0);
        tbl[9]  = row(0, ADD8, 0,0,0, 0,1,0,1, 0,0, 1, 0,0);
        tbl[10] = row(0, ADD8, 0,0,0, 0,0,0,0, 0,0, 0, 1,0);
        tbl[11] = row(0, NOP,  0,0,0, 0,0,0,0, 1,0, 1, 1,0);
        tbl[12] = row(0, BNE,  0,0,0, 0,0,0,0, 0,0, 0, 1,0);
        tbl[13] = row(0, NOP,  0,0,0, 1,0,1,1, 0,0, 1, 1,0);
        tbl[14] = row(0, BGEU, 0,0,0, 0,0,0,0, 0,0, 0, 1,1);
        tbl[15] = row(0, JALR, 0,0,1, 0,0,0,0, 0,0, 0, 1,1);
        tbl[16] = row(0, NOP,  0,0,0, 3,0,1,1, 0,0, 0, 1,1);
        tbl[17] = row(0, BEQX, 0,0,0, 0,0,0,0, 0,0, 0, 1,2);
        tbl[18] = row(0, ADD8, 1,0,0, 1,0,1,1, 1,0, 1, 1,2);
        tbl[19] = row(0, NOP,  0,0,0, 0,0,0,0, 0,0, 0, 1,3);
        tbl[20] = row(1, ADD5, 0,0,0, 0,0,0,0, 0,0, 0, 1,3);
        tbl[21] = row(1, ADD5, 0,0,0, 0,0,0,0, 0,0, 0, 0,0);
        tbl[22] = row(0, ADD5, 0,0,0, 0,0,0,0, 0,0, 0, 0,0);
        tbl[23] = row(0, NOP,  0,0,0, 0,0,0,0, 0,0, 0, 0,0);
        tbl[24] = row(0, NOP,  0,0,0, 0,0,0,0, 0,0, 0, 0,0);
        tbl[25] = row(0, NOP,  0,0,0, 0,0,0,0, 0,0, 1, 0,0);

        for (int m = 0; m < 2; m++) begin
            pe[m] = '0; pm[m] = '0; pw[m] = '0;
            scnt[m] = 0; fcnt[m] = 0;
        end
        set_in(1, NOP, 0, 0, 0);
        @(posedge clk);
        #1;

        for (int k = 0; k < 26; k++) begin
            logic [10:0] got, want;
            logic [31:0] gc, wc;
            set_in(tbl[k].rst, tbl[k].d, tbl[k].z, tbl[k].lt, tbl[k].ltu);
            sample();
            got  = {pc_f, sf_f, sd_f, fd_f, fe_f, fa_f, fb_f, rw_f};
            want = {tbl[k].pc, tbl[k].stl, tbl[k].stl, tbl[k].fd,
                    tbl[k].fe, tbl[k].fa, tbl[k].fb, tbl[k].rw};
            n++;
            if (got !== want) begin
                bad++;
                $display("FAIL row%0d_ctl got=%h want=%h", k, got, want);
            end
            gc = {sc_f, fc_f};
            wc = {tbl[k].sc[15:0], tbl[k].fc[15:0]};
            n++;
            if (gc !== wc) begin
                bad++;
                $display("FAIL row%0d_cnt got=%h want=%h", k, gc, wc);
            end
            advance();
        end

        set_in(1, NOP, 0, 0, 0);
        sample();
        advance();
        set_in(0, NOP, 0, 0, 0);
        for (int p = 0; p < 3; p++) begin
            il_stalls = 0;
            il_fwd = 0;
            set_in(0, ADD5, 0, 0, 0);
            sample();
            advance();
            for (int c = 0; c < 3; c++) begin
                set_in(0, USE5, 0, 0, 0);
                sample();
                advance();
            end
            n++;
            if (il_stalls != 2 || il_fwd != 0) begin
                bad++;
                $display("FAIL il_pair%0d stalls=%0d fwd=%0d want=2/0",
                         p, il_stalls, il_fwd);
            end
        end
        set_in(0, NOP, 0, 0, 0);
        sample();
        n++;
        if (sc_i !== 2'd3) begin
            bad++;
            $display("FAIL il_sat got=%0d want=3", sc_i);
        end
        advance();

        for (int c = 0; c < 1500; c++) begin
            rnd = ins_t'({$urandom, $urandom});
            rnd.rd  = 5'($urandom_range(0, 7));
            rnd.rs1 = 5'($urandom_range(0, 7));
            rnd.rs2 = 5'($urandom_range(0, 7));
            set_in(($urandom_range(0, 63) == 0), rnd, 1'($urandom),
                   1'($urandom), 1'($urandom));
            sample();
            advance();
        end

        $display("test done: total=%0d bad=%0d", n, bad);
        $finish;
    end

endmodule
